// File: rtl/msgpass_rd_addr_seq.sv
// Multi-channel read-address sequencer for the message-pass buffer.
// Each channel walks a programmable [start,end] window with a programmable step, stalling on DRC.
module msgpass_rd_addr_seq #(
  parameter int CH_NUM         = 2,
  parameter int ADDR_WIDTH     = 3,
  parameter int STEP_WIDTH     = 2,
  parameter int DRC_NUM        = 1,
  parameter int WRAP_CNT_WIDTH = 4
) (
  input  logic                             sys_clk,
  input  logic                             rst,
  input  logic [CH_NUM-1:0]                read_begin_i,
  input  logic [CH_NUM-1:0]                read_end_i,
  input  logic [CH_NUM*ADDR_WIDTH-1:0]     start_addr_i,
  input  logic [CH_NUM*ADDR_WIDTH-1:0]     end_addr_i,
  input  logic [CH_NUM*STEP_WIDTH-1:0]     step_i,
  input  logic [CH_NUM*DRC_NUM-1:0]        is_drc_i,
  output logic [CH_NUM*ADDR_WIDTH-1:0]     addr_o,
  output logic [CH_NUM-1:0]                valid_o,
  output logic [CH_NUM-1:0]                wrap_o,
  output logic [CH_NUM*WRAP_CNT_WIDTH-1:0] wrap_cnt_o,
  output logic [CH_NUM-1:0]                done_o,
  output logic                             busy_o
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Sum is wide enough that addr+step can never alias back into the window.
  localparam int SUM_W = ((ADDR_WIDTH > STEP_WIDTH) ? ADDR_WIDTH : STEP_WIDTH) + 1;

  logic [CH_NUM-1:0] run_next;

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    state_t                    state, state_nx;
    logic [ADDR_WIDTH-1:0]     addr, addr_nx;
    logic [ADDR_WIDTH-1:0]     win_start, start_nx;
    logic [ADDR_WIDTH-1:0]     win_end, end_nx;
    logic [STEP_WIDTH-1:0]     step, step_nx;
    logic [WRAP_CNT_WIDTH-1:0] wcnt, wcnt_nx;
    logic                      wrap, wrap_nx;
    logic                      done, done_nx;
    logic [SUM_W-1:0]          sum;
    logic [ADDR_WIDTH-1:0]     in_start, in_end;
    logic [STEP_WIDTH-1:0]     in_step;
    logic                      drc;

    assign in_start = start_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign in_end   = end_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign in_step  = step_i[k*STEP_WIDTH +: STEP_WIDTH];
    assign drc      = |is_drc_i[k*DRC_NUM +: DRC_NUM];

    always_comb begin
      state_nx = state;
      addr_nx  = addr;
      start_nx = win_start;
      end_nx   = win_end;
      step_nx  = step;
      wcnt_nx  = wcnt;
      wrap_nx  = 1'b0;
      done_nx  = 1'b0;
      sum      = SUM_W'(addr) + SUM_W'(step);
      case (state)
        IDLE: begin
          if (read_begin_i[k]) begin
            state_nx = RUN;
            start_nx = in_start;
            end_nx   = (in_end < in_start) ? in_start : in_end;
            step_nx  = (in_step == '0) ? STEP_WIDTH'(1) : in_step;
            addr_nx  = in_start;
            wcnt_nx  = '0;
          end
        end
        RUN: begin
          if (read_end_i[k]) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end else if (!drc) begin
            if (sum > SUM_W'(win_end)) begin
              addr_nx = win_start;
              wrap_nx = 1'b1;
              if (wcnt != '1) wcnt_nx = wcnt + 1'b1;
            end else begin
              addr_nx = sum[ADDR_WIDTH-1:0];
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
        state     <= IDLE;
        addr      <= '0;
        win_start <= '0;
        win_end   <= '0;
        step      <= '0;
        wcnt      <= '0;
        wrap      <= 1'b0;
        done      <= 1'b0;
      end else begin
        state     <= state_nx;
        addr      <= addr_nx;
        win_start <= start_nx;
        win_end   <= end_nx;
        step      <= step_nx;
        wcnt      <= wcnt_nx;
        wrap      <= wrap_nx;
        done      <= done_nx;
      end
    end

    assign run_next[k]                                      = (state_nx == RUN);
    assign addr_o[k*ADDR_WIDTH +: ADDR_WIDTH]               = addr;
    assign valid_o[k]                                       = (state == RUN);
    assign wrap_o[k]                                        = wrap;
    assign wrap_cnt_o[k*WRAP_CNT_WIDTH +: WRAP_CNT_WIDTH]   = wcnt;
    assign done_o[k]                                        = done;
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) busy_o <= 1'b0;
    else     busy_o <= |run_next;
  end

endmodule

// File: tb/tb_msgpass_rd_addr_seq.sv
// Randomized bench for msgpass_rd_addr_seq against a behavioural per-channel model.
// Directed scenarios run first, then random traffic; outputs sampled on the falling edge.
module tb_msgpass_rd_addr_seq;
  localparam int CH = 2;
  localparam int AW = 3;
  localparam int SW = 2;
  localparam int DW = 1;
  localparam int WW = 4;
  localparam int WMAX = (1 << WW) - 1;

  logic             sys_clk = 1'b0;
  logic             rst;
  logic [CH-1:0]    read_begin_i, read_end_i;
  logic [CH*AW-1:0] start_addr_i, end_addr_i;
  logic [CH*SW-1:0] step_i;
  logic [CH*DW-1:0] is_drc_i;
  logic [CH*AW-1:0] addr_o;
  logic [CH-1:0]    valid_o, wrap_o, done_o;
  logic [CH*WW-1:0] wrap_cnt_o;
  logic             busy_o;

  msgpass_rd_addr_seq #(
    .CH_NUM(CH), .ADDR_WIDTH(AW), .STEP_WIDTH(SW), .DRC_NUM(DW), .WRAP_CNT_WIDTH(WW)
  ) dut (
    .sys_clk(sys_clk), .rst(rst),
    .read_begin_i(read_begin_i), .read_end_i(read_end_i),
    .start_addr_i(start_addr_i), .end_addr_i(end_addr_i), .step_i(step_i),
    .is_drc_i(is_drc_i),
    .addr_o(addr_o), .valid_o(valid_o), .wrap_o(wrap_o), .wrap_cnt_o(wrap_cnt_o),
    .done_o(done_o), .busy_o(busy_o)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;

  int m_run[CH], m_addr[CH], m_start[CH], m_end[CH], m_step[CH], m_wcnt[CH];
  int m_wrap[CH], m_done[CH];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_run[c] = 0; m_addr[c] = 0; m_start[c] = 0; m_end[c] = 0;
      m_step[c] = 0; m_wcnt[c] = 0; m_wrap[c] = 0; m_done[c] = 0;
    end
  endtask

  // One clock of the reference behaviour, from the currently driven inputs.
  task automatic model_step();
    for (int c = 0; c < CH; c++) begin
      int s, e, st;
      m_wrap[c] = 0;
      m_done[c] = 0;
      if (m_run[c] == 0) begin
        if (read_begin_i[c]) begin
          s  = int'(start_addr_i[c*AW +: AW]);
          e  = int'(end_addr_i[c*AW +: AW]);
          st = int'(step_i[c*SW +: SW]);
          m_start[c] = s;
          m_end[c]   = (e < s) ? s : e;
          m_step[c]  = (st == 0) ? 1 : st;
          m_addr[c]  = s;
          m_wcnt[c]  = 0;
          m_run[c]   = 1;
        end
      end else if (read_end_i[c]) begin
        m_run[c]  = 0;
        m_done[c] = 1;
      end else if (is_drc_i[c*DW +: DW] == '0) begin
        if (m_addr[c] + m_step[c] > m_end[c]) begin
          m_addr[c] = m_start[c];
          m_wrap[c] = 1;
          if (m_wcnt[c] < WMAX) m_wcnt[c]++;
        end else begin
          m_addr[c] = m_addr[c] + m_step[c];
        end
      end
    end
  endtask

  task automatic check_outputs();
    for (int c = 0; c < CH; c++) begin
      check_eq($sformatf("addr%0d", c),  int'(addr_o[c*AW +: AW]),     m_addr[c]);
      check_eq($sformatf("valid%0d", c), int'(valid_o[c]),             m_run[c]);
      check_eq($sformatf("wrap%0d", c),  int'(wrap_o[c]),              m_wrap[c]);
      check_eq($sformatf("wcnt%0d", c),  int'(wrap_cnt_o[c*WW +: WW]), m_wcnt[c]);
      check_eq($sformatf("done%0d", c),  int'(done_o[c]),              m_done[c]);
    end
    check_eq("busy", int'(busy_o), (m_run[0] != 0 || m_run[1] != 0) ? 1 : 0);
  endtask

  // Inputs are driven on the falling edge; the model advances for the next rising edge.
  task automatic cycle(input logic [CH-1:0] b, input logic [CH-1:0] e, input logic [CH*DW-1:0] d);
    read_begin_i = b;
    read_end_i   = e;
    is_drc_i     = d;
    model_step();
    @(posedge sys_clk);
    @(negedge sys_clk);
    check_outputs();
  endtask

  task automatic set_win(input int c, input int s, input int e, input int st);
    start_addr_i[c*AW +: AW] = AW'(s);
    end_addr_i[c*AW +: AW]   = AW'(e);
    step_i[c*SW +: SW]       = SW'(st);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, '0, '0);
  endtask

  initial begin
    rst = 1'b1;
    read_begin_i = '0; read_end_i = '0; is_drc_i = '0;
    start_addr_i = '0; end_addr_i = '0; step_i = '0;
    model_reset();
    @(negedge sys_clk);
    check_outputs();
    @(negedge sys_clk);
    rst = 1'b0;

    // Window 0..4 step 1: 0,1,2,3,4 then wrap to 0
    set_win(0, 0, 4, 1);
    cycle(2'b01, '0, '0);
    idle(5);
    check_eq("tp1_addr", int'(addr_o[AW-1:0]), 0);
    check_eq("tp1_wrap", int'(wrap_o[0]), 1);
    check_eq("tp1_wcnt", int'(wrap_cnt_o[WW-1:0]), 1);
    cycle('0, 2'b01, '0);

    // Window 1..6 step 2: 1,3,5,1
    set_win(0, 1, 6, 2);
    cycle(2'b01, '0, '0);
    idle(3);
    check_eq("tp2_addr", int'(addr_o[AW-1:0]), 1);
    check_eq("tp2_wrap", int'(wrap_o[0]), 1);
    cycle('0, 2'b01, '0);

    // DRC stall at addr 2, then end together with DRC
    set_win(0, 0, 7, 1);
    cycle(2'b01, '0, '0);
    idle(2);
    for (int i = 0; i < 3; i++) cycle('0, '0, 2'b01);
    check_eq("tp3_hold", int'(addr_o[AW-1:0]), 2);
    idle(1);
    check_eq("tp3_next", int'(addr_o[AW-1:0]), 3);
    cycle('0, 2'b01, 2'b01);
    check_eq("tp3_done", int'(done_o[0]), 1);
    check_eq("tp3_valid", int'(valid_o[0]), 0);

    // Both channels together with different windows
    set_win(0, 0, 2, 1);
    set_win(1, 4, 7, 3);
    cycle(2'b11, '0, '0);
    idle(3);
    cycle('0, 2'b01, '0);
    idle(1);
    check_eq("tp4_busy", int'(busy_o), 1);
    cycle('0, 2'b10, '0);
    check_eq("tp4_idle", int'(busy_o), 0);

    // Degenerate window: end<start, step 0, wrap counter saturates
    set_win(0, 5, 2, 0);
    cycle(2'b01, '0, '0);
    idle(17);
    check_eq("tp5_sat", int'(wrap_cnt_o[WW-1:0]), WMAX);
    check_eq("tp5_addr", int'(addr_o[AW-1:0]), 5);
    cycle('0, 2'b01, '0);

    // Reset while running at addr 3 aborts without done
    set_win(0, 0, 7, 1);
    cycle(2'b01, '0, '0);
    idle(3);
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(negedge sys_clk);
    check_outputs();
    rst = 1'b0;
    set_win(0, 6, 7, 1);
    cycle(2'b01, '0, '0);
    check_eq("tp6_restart", int'(addr_o[AW-1:0]), 6);
    cycle('0, 2'b01, '0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [CH-1:0] b, e;
      logic [CH*DW-1:0] d;
      for (int c = 0; c < CH; c++) begin
        set_win(c, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
        b[c] = ($urandom_range(0, 5) == 0);
        e[c] = ($urandom_range(0, 15) == 0);
        d[c*DW +: DW] = DW'($urandom_range(0, 3) == 0);
      end
      cycle(b, e, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
